// File: rtl/add16_pipe_pkg.sv
// Shared types and helpers for the pipelined carry-lookahead adder.
package add_pkg;

   localparam int GRP = 4;

   typedef struct packed {
      logic p;
      logic g;
   } pg_t;

   function automatic int ngrp(input int width);
      return width / GRP;
   endfunction

   // Group propagate/generate of one 4-bit slice; independent of carry-in.
   function automatic pg_t grp_pg(input logic [GRP-1:0] a, input logic [GRP-1:0] b);
      logic [GRP-1:0] p;
      logic [GRP-1:0] g;
      pg_t            r;
      p   = a ^ b;
      g   = a & b;
      r.p = &p;
      r.g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
      return r;
   endfunction

endpackage

// File: rtl/add16_pipe_cla4.sv
// 4-bit augmented carry-lookahead slice: sum bits from operands and a group carry-in.
module cla4_slice
   import add_pkg::*;
(
   input  logic [GRP-1:0] a,
   input  logic [GRP-1:0] b,
   input  logic           cin,
   output logic [GRP-1:0] s
);

   logic [GRP-1:0] p_s;
   logic [GRP-1:0] g_s;
   logic [GRP-1:0] c_s;

   assign p_s = a ^ b;
   assign g_s = a & b;

   assign c_s[0] = cin;
   assign c_s[1] = g_s[0] | (p_s[0] & cin);
   assign c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & cin);
   assign c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
                 | (p_s[2] & p_s[1] & p_s[0] & cin);

   assign s = p_s ^ c_s;

endmodule

// File: rtl/add16_pipe_lcu4.sv
// Single-level lookahead carry unit over four (P,G) groups, fully expanded.
module lcu4 (
   input  logic [3:0] p,
   input  logic [3:0] g,
   input  logic       cin,
   output logic [3:0] c,
   output logic       blk_p,
   output logic       blk_g
);

   // c[i] is the carry out of group i, i.e. the carry into group i+1.
   assign c[0] = g[0] | (p[0] & cin);
   assign c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
   assign c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
   assign c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & cin);

   assign blk_p = &p;
   assign blk_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);

endmodule

// File: rtl/add16_pipe.sv
// Two-stage pipelined CLA adder: stage 1 registers operands and group P/G,
// stage 2 resolves group carries through the LCU and registers the result.
module add16_pipe
   import add_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             pout,
   output logic             gout,
   output logic             ovf
);

   localparam int NGRP = ngrp(WIDTH);

   logic             s1_v_q, s1_v_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             cin_q, cin_d;
   pg_t [NGRP-1:0]   pg_q, pg_d;

   logic             s2_v_q, s2_v_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             pout_q, pout_d;
   logic             gout_q, gout_d;
   logic             ovf_q, ovf_d;

   logic             s2_ready_s;
   logic             in_xfer_s;
   logic [3:0]       lcu_p_s, lcu_g_s, lcu_c_s;
   logic             blk_p_s, blk_g_s;
   logic [NGRP-1:0]  gcin_s;
   logic [WIDTH-1:0] slice_sum_s;

   assign s2_ready_s = !s2_v_q || out_ready;
   assign in_ready   = !s1_v_q || s2_ready_s;
   assign in_xfer_s  = in_valid && in_ready;

   // Stage 1 next state: capture operands and group P/G on input transfer.
   always_comb begin
      a_d    = a_q;
      b_d    = b_q;
      cin_d  = cin_q;
      pg_d   = pg_q;
      s1_v_d = s1_v_q;
      if (in_xfer_s) begin
         a_d    = a;
         b_d    = b;
         cin_d  = cin;
         s1_v_d = 1'b1;
         for (int gi = 0; gi < NGRP; gi++) begin
            pg_d[gi] = grp_pg(a[gi*GRP +: GRP], b[gi*GRP +: GRP]);
         end
      end else if (s2_ready_s) begin
         s1_v_d = 1'b0;
      end else begin
         s1_v_d = s1_v_q;
      end
   end

   // Unused upper LCU lanes act as transparent groups (P=1, G=0).
   for (genvar gi = 0; gi < 4; gi++) begin : g_lcu_in
      if (gi < NGRP) begin : g_real
         assign lcu_p_s[gi] = pg_q[gi].p;
         assign lcu_g_s[gi] = pg_q[gi].g;
      end else begin : g_tie
         assign lcu_p_s[gi] = 1'b1;
         assign lcu_g_s[gi] = 1'b0;
      end
   end

   lcu4 u_lcu (
      .p     (lcu_p_s),
      .g     (lcu_g_s),
      .cin   (cin_q),
      .c     (lcu_c_s),
      .blk_p (blk_p_s),
      .blk_g (blk_g_s)
   );

   for (genvar gi = 0; gi < NGRP; gi++) begin : g_slice
      if (gi == 0) begin : g_first
         assign gcin_s[gi] = cin_q;
      end else begin : g_rest
         assign gcin_s[gi] = lcu_c_s[gi-1];
      end

      cla4_slice u_slice (
         .a   (a_q[gi*GRP +: GRP]),
         .b   (b_q[gi*GRP +: GRP]),
         .cin (gcin_s[gi]),
         .s   (slice_sum_s[gi*GRP +: GRP])
      );
   end

   // Stage 2 next state: results only move when the output slot is free.
   always_comb begin
      sum_d  = sum_q;
      cout_d = cout_q;
      pout_d = pout_q;
      gout_d = gout_q;
      ovf_d  = ovf_q;
      s2_v_d = s2_v_q;
      if (s2_ready_s) begin
         s2_v_d = s1_v_q;
         if (s1_v_q) begin
            sum_d  = slice_sum_s;
            cout_d = lcu_c_s[NGRP-1];
            pout_d = blk_p_s;
            gout_d = blk_g_s;
            // Carry into the MSB xor carry out of the MSB.
            ovf_d  = (a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ slice_sum_s[WIDTH-1]) ^ lcu_c_s[NGRP-1];
         end else begin
            sum_d = sum_q;
         end
      end else begin
         s2_v_d = s2_v_q;
      end
   end

   // Pipeline registers for both stages.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v_q <= 1'b0;
         a_q    <= '0;
         b_q    <= '0;
         cin_q  <= 1'b0;
         pg_q   <= '0;
         s2_v_q <= 1'b0;
         sum_q  <= '0;
         cout_q <= 1'b0;
         pout_q <= 1'b0;
         gout_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         s1_v_q <= s1_v_d;
         a_q    <= a_d;
         b_q    <= b_d;
         cin_q  <= cin_d;
         pg_q   <= pg_d;
         s2_v_q <= s2_v_d;
         sum_q  <= sum_d;
         cout_q <= cout_d;
         pout_q <= pout_d;
         gout_q <= gout_d;
         ovf_q  <= ovf_d;
      end
   end

   assign out_valid = s2_v_q;
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign pout      = pout_q;
   assign gout      = gout_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_add16_pipe.sv
// Scoreboard bench for add16_pipe: directed vectors, streaming, stall and reset.
module tb_add16_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        cin;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] sum;
   logic        cout, pout, gout, ovf;

   typedef struct {
      logic [15:0] sum;
      logic        cout;
      logic        pout;
      logic        gout;
      logic        ovf;
      int          pres;
      bit          lat;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_pass   = 0;
   int   cyc      = 0;

   add16_pipe #(.WIDTH(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .pout      (pout),
      .gout      (gout),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic exp_t model(input logic [15:0] xa, input logic [15:0] xb, input logic xc);
      exp_t        m;
      logic [16:0] f;
      logic [16:0] f0;
      f      = {1'b0, xa} + {1'b0, xb} + {16'd0, xc};
      f0     = {1'b0, xa} + {1'b0, xb};
      m.sum  = f[15:0];
      m.cout = f[16];
      m.pout = &(xa ^ xb);
      m.gout = f0[16];
      m.ovf  = (xa[15] == xb[15]) && (f[15] != xa[15]);
      m.pres = 0;
      m.lat  = 1'b0;
      return m;
   endfunction

   task automatic send(input logic [15:0] xa, input logic [15:0] xb, input logic xc, input bit lat);
      exp_t e;
      bit   done;
      e        = model(xa, xb, xc);
      e.lat    = lat;
      done     = 1'b0;
      in_valid = 1'b1;
      a        = xa;
      b        = xb;
      cin      = xc;
      for (int k = 0; k < 50 && !done; k++) begin
         @(negedge clk);
         if (in_ready) begin
            e.pres = cyc;
            sb.push_back(e);
            done   = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (!done) begin
         n_checks++;
         $error("FAIL send_timeout: observed no accept expected accept within 50 cycles");
      end
   endtask

   task automatic drain(input string tag);
      for (int k = 0; k < 40 && sb.size() != 0; k++) @(posedge clk);
      @(posedge clk);
      #1;
      chk(tag, sb.size(), 0);
   endtask

   // Output monitor: every result handed to the consumer is checked against the queue head.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            n_checks++;
            $error("FAIL spurious_out: observed result %0h expected none", sum);
         end else begin
            mon_e = sb.pop_front();
            chk("sum",  sum,  mon_e.sum);
            chk("cout", cout, mon_e.cout);
            chk("pout", pout, mon_e.pout);
            chk("gout", gout, mon_e.gout);
            chk("ovf",  ovf,  mon_e.ovf);
            if (mon_e.lat) chk("latency", cyc - mon_e.pres, 2);
         end
      end
   end

   initial begin
      logic [15:0] ra, rb;
      logic        rc;
      exp_t        first;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      a         = 16'h0000;
      b         = 16'h0000;
      cin       = 1'b0;
      #3;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_sum",       sum,       0);
      chk("rst_cout",      cout,      0);
      chk("rst_pout",      pout,      0);
      chk("rst_gout",      gout,      0);
      chk("rst_ovf",       ovf,       0);
      chk("rst_in_ready",  in_ready,  1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Directed corner vectors, sent back to back.
      send(16'hFFFF, 16'h0001, 1'b0, 1'b1);
      send(16'h7FFF, 16'h0001, 1'b0, 1'b1);
      send(16'h5555, 16'hAAAA, 1'b1, 1'b1);
      send(16'h5555, 16'hAAAA, 1'b0, 1'b1);
      send(16'h8000, 16'h8000, 1'b0, 1'b1);
      drain("drain_directed");

      // Random stream, one per cycle, no backpressure.
      for (int i = 0; i < 8; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         rc = 1'($urandom_range(1, 0));
         send(ra, rb, rc, 1'b1);
      end
      drain("drain_stream");

      // Stall: two accepted, third refused while the consumer is blocked.
      out_ready = 1'b0;
      send(16'h1234, 16'h1111, 1'b0, 1'b0);
      send(16'hF000, 16'h1000, 1'b1, 1'b0);
      first    = model(16'h1234, 16'h1111, 1'b0);
      in_valid = 1'b1;
      a        = 16'h0F0F;
      b        = 16'h00F1;
      cin      = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("stall_in_ready",  in_ready,  0);
         chk("stall_out_valid", out_valid, 1);
         chk("stall_sum",       sum,       first.sum);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      send(16'h0F0F, 16'h00F1, 1'b1, 1'b0);
      drain("drain_stall");

      // Reset with two transactions in flight.
      send(16'h0101, 16'h0202, 1'b0, 1'b0);
      send(16'h7777, 16'h1111, 1'b1, 1'b0);
      chk("pre_rst_out_valid", out_valid, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_sum",       sum,       0);
      chk("mid_rst_cout",      cout,      0);
      chk("mid_rst_in_ready",  in_ready,  1);
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      send(16'hABCD, 16'h1234, 1'b1, 1'b1);
      drain("drain_post_rst");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
